// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NREQ byte sources.
// Grants one byte per frame and tracks tx_busy before arbitrating again.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int DATA_W  = 8,
   parameter int BUSY_TO = 4,
   localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ack,
   output logic                   tx_start,
   output logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_busy,
   output logic [GW-1:0]          grant_id,
   output logic                   active,
   output logic                   err_timeout
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_BUSY = 2'd1;
   localparam logic [1:0] S_WAIT_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        to_cnt_q, to_cnt_d;
   logic [3:0]        to_cnt_inc;
   logic              tx_start_q, tx_start_d;
   logic [NREQ-1:0]   req_ack_q, req_ack_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     last_q, last_d;
   logic              active_q, active_d;
   logic              err_q, err_d;

   int                rr_idx;
   logic [GW-1:0]     cand;
   logic [GW-1:0]     winner;
   logic              found;

   // Search starts one past the last grant and wraps, so every valid source
   // is served before any source is served twice.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      rr_idx = 0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         rr_idx = int'(last_q) + k;
         if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
         cand = rr_idx[GW-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign to_cnt_inc = to_cnt_q + 4'd1;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      tx_start_d = 1'b0;
      req_ack_d  = '0;
      tx_data_d  = tx_data_q;
      grant_d    = grant_q;
      last_d     = last_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (en && found) begin
               grant_d           = winner;
               tx_data_d         = req_data[int'(winner)*DATA_W +: DATA_W];
               req_ack_d[winner] = 1'b1;
               tx_start_d        = 1'b1;
               last_d            = winner;
               to_cnt_d          = 4'd0;
               state_d           = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else begin
               to_cnt_d = to_cnt_inc;
               // A timed-out byte is treated as sent; it is never re-popped.
               if (to_cnt_inc == 4'(BUSY_TO)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      active_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         to_cnt_q   <= 4'd0;
         tx_start_q <= 1'b0;
         req_ack_q  <= '0;
         tx_data_q  <= '0;
         grant_q    <= '0;
         last_q     <= GW'(NREQ - 1);
         active_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         tx_start_q <= tx_start_d;
         req_ack_q  <= req_ack_d;
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         active_q   <= active_d;
         err_q      <= err_d;
      end
   end

   assign req_ack     = req_ack_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign active      = active_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, hand sequences for
// enable/reset corners, and randomized transactions against a queue-based model.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int DATA_W  = 8;
   localparam int BUSY_TO = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        err_timeout;

   uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .BUSY_TO(BUSY_TO)) dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
      .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: last granted index and sticky timeout flag.
   int   m_last = NREQ - 1;
   logic m_err  = 1'b0;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic        en;
      int          d;
      int          len;
      logic        go;
      int          w;
      logic [7:0]  b;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Winner = lowest valid index above the last grant, else lowest valid index.
   function automatic int rr_pick(input logic [3:0] v, input int last);
      int q[$];
      for (int i = 0; i < NREQ; i++) if (v[i]) q.push_back(i);
      if (q.size() == 0) return -1;
      foreach (q[i]) if (q[i] > last) return q[i];
      return q[0];
   endfunction

   // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   // d = idle-busy cycles after tx_start, len = busy-high cycles.
   task automatic do_txn(input logic [3:0] v, input logic [31:0] dat, input logic e,
                         input int d, input int len, input logic go, input int w,
                         input logic [7:0] b, input logic err_after);
      logic [3:0] oh;
      int n_cyc;
      req_valid = v;
      req_data  = dat;
      en        = e;
      tx_busy   = 1'b0;
      @(negedge clk);
      if (!go) begin
         check("nogo_start", tx_start, 0);
         check("nogo_ack", req_ack, 0);
         check("nogo_active", active, 0);
         check("nogo_err", err_timeout, m_err);
         m_err = err_after;
         return;
      end
      oh    = 4'b0001 << w;
      n_cyc = (d >= BUSY_TO) ? BUSY_TO : d + len + 1;
      for (int j = 0; j < n_cyc; j++) begin
         check("start", tx_start, (j == 0) ? 1 : 0);
         check("ack", req_ack, (j == 0) ? oh : 4'b0000);
         check("active", active, 1);
         check("tx_data", tx_data, b);
         check("grant_id", grant_id, w);
         check("err_hold", err_timeout, m_err);
         tx_busy   = (d < BUSY_TO) && (j >= d) && (j < d + len);
         req_valid = 4'($urandom);
         req_data  = $urandom;
         en        = 1'b0;
         @(negedge clk);
      end
      check("end_active", active, 0);
      check("end_start", tx_start, 0);
      check("end_err", err_timeout, err_after);
      check("end_data_hold", tx_data, b);
      check("end_grant_hold", grant_id, w);
      m_last = w;
      m_err  = err_after;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_start", tx_start, 0);
      check("rst_ack", req_ack, 0);
      check("rst_data", tx_data, 0);
      check("rst_grant", grant_id, 0);
      check("rst_active", active, 0);
      check("rst_err", err_timeout, 0);
      req_valid = '0;
      en        = 1'b0;
      tx_busy   = 1'b0;
      @(negedge clk);
      rst    = 1'b0;
      m_last = NREQ - 1;
      m_err  = 1'b0;
   endtask

   task automatic rand_txn();
      logic [3:0]  v;
      logic [31:0] dat;
      logic        e, go, ea;
      int          d, len, w;
      logic [7:0]  b;
      v   = 4'($urandom_range(0, 15));
      dat = $urandom;
      e   = ($urandom_range(0, 9) != 0);
      d   = $urandom_range(0, BUSY_TO + 1);
      len = $urandom_range(1, 4);
      go  = e && (v != 4'b0000);
      w   = go ? rr_pick(v, m_last) : 0;
      b   = go ? dat[w*8 +: 8] : 8'h00;
      ea  = m_err | (go && (d >= BUSY_TO));
      do_txn(v, dat, e, d, len, go, w, b, ea);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_busy   = 1'b0;

      tbl.push_back('{4'b0001, 32'h0000_0055, 1'b1, 0, 3, 1'b1, 0, 8'h55, 1'b0});
      tbl.push_back('{4'b1000, 32'h7700_0000, 1'b1, 1, 2, 1'b1, 3, 8'h77, 1'b0});
      tbl.push_back('{4'b1111, 32'hA3A2_A1A0, 1'b1, 0, 1, 1'b1, 0, 8'hA0, 1'b0});
      tbl.push_back('{4'b1111, 32'hA3A2_A1A0, 1'b1, 2, 2, 1'b1, 1, 8'hA1, 1'b0});
      tbl.push_back('{4'b1111, 32'hA3A2_A1A0, 1'b1, 1, 1, 1'b1, 2, 8'hA2, 1'b0});
      tbl.push_back('{4'b1111, 32'hA3A2_A1A0, 1'b1, 3, 1, 1'b1, 3, 8'hA3, 1'b0});
      tbl.push_back('{4'b1111, 32'hA3A2_A1A0, 1'b1, 0, 2, 1'b1, 0, 8'hA0, 1'b0});
      tbl.push_back('{4'b1000, 32'hB3B2_B1B0, 1'b1, 0, 1, 1'b1, 3, 8'hB3, 1'b0});
      tbl.push_back('{4'b1010, 32'hB3B2_B1B0, 1'b1, 0, 1, 1'b1, 1, 8'hB1, 1'b0});
      tbl.push_back('{4'b1010, 32'hB3B2_B1B0, 1'b1, 1, 1, 1'b1, 3, 8'hB3, 1'b0});
      tbl.push_back('{4'b1010, 32'hB3B2_B1B0, 1'b1, 0, 2, 1'b1, 1, 8'hB1, 1'b0});
      tbl.push_back('{4'b1111, 32'hA3A2_A1A0, 1'b0, 0, 1, 1'b0, 0, 8'h00, 1'b0});
      tbl.push_back('{4'b0100, 32'h00C2_0000, 1'b1, 4, 1, 1'b1, 2, 8'hC2, 1'b1});
      tbl.push_back('{4'b0001, 32'h0000_0011, 1'b1, 0, 1, 1'b1, 0, 8'h11, 1'b1});

      @(negedge clk);
      do_reset();

      foreach (tbl[i])
         do_txn(tbl[i].valid, tbl[i].data, tbl[i].en, tbl[i].d, tbl[i].len,
                tbl[i].go, tbl[i].w, tbl[i].b, tbl[i].err);

      // en held low with requests pending after a frame: no new grant, then resume.
      do_txn(4'b1111, 32'hA3A2_A1A0, 1'b1, 0, 2, 1'b1, 1, 8'hA1, 1'b1);
      req_valid = 4'b1111;
      req_data  = 32'hA3A2_A1A0;
      en        = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("en_low_start", tx_start, 0);
         check("en_low_active", active, 0);
      end
      do_txn(4'b1111, 32'hA3A2_A1A0, 1'b1, 1, 1, 1'b1, 2, 8'hA2, 1'b1);

      // Reset while in WAIT_DONE, then requester 0 wins first.
      req_valid = 4'b0010;
      req_data  = 32'h0000_D100;
      en        = 1'b1;
      @(negedge clk);
      check("rstseq_start", tx_start, 1);
      check("rstseq_ack", req_ack, 4'b0010);
      check("rstseq_data", tx_data, 8'hD1);
      tx_busy = 1'b1;
      en      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstseq_active", active, 1);
      do_reset();
      do_txn(4'b1111, 32'hA3A2_A1A0, 1'b1, 0, 1, 1'b1, 0, 8'hA0, 1'b0);

      for (int i = 0; i < 200; i++) begin
         if (i % 40 == 39) do_reset();
         rand_txn();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer among NREQ byte sources (typically first-word-fall-through FIFO outputs). It selects a requester, pops one byte from it, drives `tx_start`/`tx_data` into `uart_tx`, and tracks `tx_busy` until the frame completes before arbitrating again. It sits between the per-channel FIFOs and the single UART transmit line. The same `uart_tx` handshake (`tx_start` pulse, `busy` level) is used unchanged.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal 2..8
- DATA_W, 8, byte width
- BUSY_TO, 4, cycles to wait for `tx_busy` to rise after `tx_start` before declaring a timeout; legal 1..15

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- en  in  1  when low, no new grant is issued; a transfer in progress completes normally
- req_valid  in  NREQ  bit i high: requester i presents a byte
- req_data  in  NREQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
- req_ack  out  NREQ  one-cycle pop strobe to the granted requester
- tx_start  out  1  one-cycle start pulse to `uart_tx`
- tx_data  out  DATA_W  byte to `uart_tx`; stable from `tx_start` until return to IDLE
- tx_busy  in  1  `uart_tx` busy level
- grant_id  out  max(1,clog2(NREQ))  index of the current/last granted requester
- active  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; set when `tx_busy` does not rise within BUSY_TO cycles; cleared only by reset

## Operation
- State machine: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if `en` and any `req_valid` bit is set, pick a winner by round-robin, starting the search at (`last_grant`+1) mod NREQ and wrapping. Register `grant_id`<=winner, `tx_data`<=winner's byte, `req_ack[winner]`<=1, `tx_start`<=1, `last_grant`<=winner, clear `to_cnt`, and go to WAIT_BUSY. Otherwise stay in IDLE.
- WAIT_BUSY: `tx_start` and `req_ack` are already back to 0 (single-cycle registered pulses).
  - If `tx_busy`=1, go to WAIT_DONE.
  - Else increment `to_cnt`. When `to_cnt` reaches BUSY_TO, set `err_timeout` and go to IDLE; the byte counts as sent and is not re-popped.
- WAIT_DONE: when `tx_busy`=0, go to IDLE. There is no timeout in this state.
- `req_valid` and `req_data` are sampled only in IDLE. Changes during other states are ignored.
- `en` is sampled only in IDLE.
- Requesters whose `req_valid` is low are skipped. A requester that is the only one valid wins on every arbitration.
- `last_grant` resets to NREQ-1, so requester 0 has first priority after reset.
- Reset values: `tx_start`=0, `req_ack`=0, `tx_data`=0, `grant_id`=0, `active`=0, `err_timeout`=0, state=IDLE, `to_cnt`=0. Reset mid-transfer abandons tracking immediately. Any frame already inside `uart_tx` is not this block's concern.

## Timing
- Arbitration decision in the IDLE cycle n. `tx_start`, `req_ack[w]` and the new `tx_data`/`grant_id` are all visible in cycle n+1 for exactly one cycle, except `tx_data`/`grant_id`, which hold.
- The requester pops on `req_ack` at the same edge `uart_tx` samples `tx_start`.
- At least one IDLE cycle separates consecutive grants. Back-to-back throughput is one byte per (frame time + 2) cycles.
- `tx_busy` rising in the same cycle as `tx_start` is seen in WAIT_BUSY on the next cycle and counts as a normal start.
- The timeout fires on the BUSY_TO-th consecutive WAIT_BUSY cycle with `tx_busy`=0.
- `active` is a registered decode of state: high from cycle n+1 until the cycle after `tx_busy` falls.

## Test plan
- Reset, then `req_valid`=4'b0001, `req_data[7:0]`=0x55 → `tx_start` and `req_ack`=4'b0001 for one cycle; `tx_data`=0x55, `grant_id`=0; no further grant until `tx_busy` falls.
- All four requesters valid continuously with bytes 0xA0..0xA3 → transmitted order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0; each `req_ack` is exactly one cycle.
- `req_valid`=4'b1010 after a grant to requester 3 → next grant is 1, then 3, then 1 (wrap and skip).
- `tx_busy` held at 0 with BUSY_TO=4 → `err_timeout` rises 4 cycles after `tx_start` and stays set; the next grant still proceeds normally.
- `en`=0 while requests are pending → no `tx_start`. Drop `en` during WAIT_DONE → the current frame completes and no new grant follows. Raise `en` again → arbitration resumes at `last_grant`+1.
- Assert `rst` in WAIT_DONE → all outputs are 0 immediately; after release, requester 0 wins first.
